// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int RAM_WIDTH     = 16;
  localparam int RAM_ADDR_BITS = 12;

  // Requester identity carried through the tag pipeline.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // One tag pipeline stage: is there an access in flight, and whose is it.
  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Grant selection for the RAM arbiter.
// RAM_ARB_ROUND_ROBIN_EN defined  : a conflict goes to the port not granted most recently.
// RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port A wins every conflict, no pointer register.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic A_REQ,
  input  logic B_REQ,
  output logic A_GNT,
  output logic B_GNT
);

  // High when port B should win the next conflict.
  logic b_first;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Pointer moves only when someone is actually granted.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      b_first <= 1'b0;
    end else if (A_GNT) begin
      b_first <= 1'b1;
    end else if (B_GNT) begin
      b_first <= 1'b0;
    end
  end
`else
  logic unused_clk;

  assign b_first    = 1'b0;
  assign unused_clk = CLK;
`endif

  // Combinational winner; grants are held low while reset is asserted.
  // NOTE: outputs get a default before any branch, so no path leaves them unassigned (no latch).
  always_comb begin
    A_GNT = 1'b0;
    B_GNT = 1'b0;
    if (RST_N) begin
      if (A_REQ && !(B_REQ && b_first)) begin
        A_GNT = 1'b1;
      end else if (B_REQ) begin
        B_GNT = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a 4096 x 16 single-port synchronous RAM.
// Grants one access per cycle, registers it onto the RAM pins, and steers the
// one-cycle-latency RAM result back to its owner through a two-stage tag pipe.
// Optional build macro: RAM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed A priority).
module ram_arbiter
  import ram_arb_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RST_N,

  input  logic                     A_REQ,
  input  logic                     A_WRITE,
  input  logic [RAM_ADDR_BITS-1:0] A_ADDR,
  input  logic [RAM_WIDTH-1:0]     A_WDATA,
  output logic                     A_GNT,
  output logic                     A_RVALID,
  output logic [RAM_WIDTH-1:0]     A_RDATA,

  input  logic                     B_REQ,
  input  logic                     B_WRITE,
  input  logic [RAM_ADDR_BITS-1:0] B_ADDR,
  input  logic [RAM_WIDTH-1:0]     B_WDATA,
  output logic                     B_GNT,
  output logic                     B_RVALID,
  output logic [RAM_WIDTH-1:0]     B_RDATA,

  output logic                     RAM_ENABLE,
  output logic                     RAM_WRITE,
  output logic [RAM_ADDR_BITS-1:0] RAM_ADDR,
  output logic [RAM_WIDTH-1:0]     RAM_DATA_IN,
  input  logic [RAM_WIDTH-1:0]     RAM_DATA_OUT
);

  logic                     any_gnt;
  port_e                    gnt_port;
  logic                     sel_write;
  logic [RAM_ADDR_BITS-1:0] sel_addr;
  logic [RAM_WIDTH-1:0]     sel_wdata;
  tag_t                     tag_s1;
  tag_t                     tag_s2;

  ram_arb_pick u_pick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .A_REQ (A_REQ),
    .B_REQ (B_REQ),
    .A_GNT (A_GNT),
    .B_GNT (B_GNT)
  );

  assign any_gnt  = A_GNT | B_GNT;
  assign gnt_port = B_GNT ? PORT_B : PORT_A;

  // Mux the winning port's command onto the RAM command inputs.
  always_comb begin
    sel_write = A_WRITE;
    sel_addr  = A_ADDR;
    sel_wdata = A_WDATA;
    if (B_GNT) begin
      sel_write = B_WRITE;
      sel_addr  = B_ADDR;
      sel_wdata = B_WDATA;
    end
  end

  // Command stage: enable pulses for one cycle per grant; other pins hold when idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RAM_ENABLE  <= 1'b0;
      RAM_WRITE   <= 1'b0;
      RAM_ADDR    <= '0;
      RAM_DATA_IN <= '0;
    end else begin
      RAM_ENABLE <= any_gnt;
      if (any_gnt) begin
        RAM_WRITE   <= sel_write;
        RAM_ADDR    <= sel_addr;
        RAM_DATA_IN <= sel_wdata;
      end
    end
  end

  // Tag pipe: stage 1 lines up with the RAM command, stage 2 with RAM_DATA_OUT.
  // Clearing it on reset drops any in-flight responses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1 <= tag_t'{valid: any_gnt, port: gnt_port};
      tag_s2 <= tag_s1;
    end
  end

  // Route the RAM result to the owning port; the other port sees zeros.
  always_comb begin
    A_RVALID = tag_s2.valid && (tag_s2.port == PORT_A);
    B_RVALID = tag_s2.valid && (tag_s2.port == PORT_B);
    A_RDATA  = A_RVALID ? RAM_DATA_OUT : '0;
    B_RDATA  = B_RVALID ? RAM_DATA_OUT : '0;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 4096 x 16 synchronous block RAM between two requesters: port A (CPU data path) and port B (DMA/peripheral engine). It takes one access per cycle, issues it to the RAM through a registered command stage, and routes the one-cycle-latency RAM result back to the owning port through a two-stage tag pipeline. It sits between the requesters and the RAM and is the only block that drives the RAM command pins.

## Interface
- RAM_WIDTH, 16, data width in bits.
- RAM_ADDR_BITS, 12, address width in bits.
- CLK  in  1  system clock; every register updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- A_REQ / B_REQ  in  1  access request; held high until the matching GNT.
- A_WRITE / B_WRITE  in  1  1 = write, 0 = read.
- A_ADDR / B_ADDR  in  RAM_ADDR_BITS  word address.
- A_WDATA / B_WDATA  in  RAM_WIDTH  write data.
- A_GNT / B_GNT  out  1  combinational; high in the cycle the request is accepted.
- A_RVALID / B_RVALID  out  1  one-cycle response pulse, for both reads and writes.
- A_RDATA / B_RDATA  out  RAM_WIDTH  read data (write data for writes) while RVALID is high, else 0.
- RAM_ENABLE  out  1  registered; drives the RAM enable.
- RAM_WRITE  out  1  registered; drives the RAM write strobe.
- RAM_ADDR  out  RAM_ADDR_BITS  registered; drives the RAM address.
- RAM_DATA_IN  out  RAM_WIDTH  registered; drives the RAM write data.
- RAM_DATA_OUT  in  RAM_WIDTH  RAM output register; valid one cycle after RAM_ENABLE.

## Operation
- The arbiter accepts at most one request per cycle and never asserts A_GNT and B_GNT in the same cycle.
- Only one requester active: that requester is granted in the same cycle.
- Both requesters active: the winner is chosen by the policy in Configuration.
- The accepted command (write, address, data) is registered into the RAM_* outputs. RAM_ENABLE is 1 for exactly one cycle per grant.
- Tag pipeline: two stages of {valid, port}. Stage 1 is aligned with the RAM command cycle; stage 2 is aligned with the cycle RAM_DATA_OUT is valid.
- When stage 2 is valid, the arbiter pulses RVALID on the tagged port and routes RAM_DATA_OUT to that port's RDATA.
- Writes: the RAM is write-through, so RDATA on a write response carries the written data.
- Protocol: a requester must not change WRITE, ADDR or WDATA while REQ is high without a GNT. If it does, the result is undefined and not checked.
- Reset (RST_N low, at any time):
  - RAM_ENABLE, RAM_WRITE, RAM_ADDR, RAM_DATA_IN = 0.
  - Both tag stages cleared, so A_RVALID, B_RVALID, A_RDATA, B_RDATA = 0.
  - A_GNT and B_GNT forced to 0.
  - Round-robin pointer set so that port A wins next.
- In-flight accesses are dropped on reset: no RVALID is issued for them. A write already registered to the RAM may or may not land. RAM contents are never cleared.

## Timing
- Cycle t: REQ high and granted, GNT high in t.
- Cycle t+1: RAM_ENABLE high with the command.
- Cycle t+2: RVALID high and RDATA valid. Latency from grant to response is 2 cycles, for reads and writes.
- Throughput: one access per cycle, back-to-back, in any read/write mix.
- Read-after-write to the same address in consecutive grants returns the new data, because RAM order equals grant order.
- REQ deasserting in the same cycle it is granted: legal. REQ held high after a grant: a new request in the next cycle.
- Responses return in grant order; they are never reordered.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined:
  - On a conflict, the port not granted most recently wins. The pointer updates only on a grant.
  - A continuously contending port is granted at least every 2nd cycle.
- RAM_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: port A always wins a conflict. Port B may starve.
  - No pointer register is built.

## Structure
- Package ram_arb_pkg holds:
  - RAM_WIDTH and RAM_ADDR_BITS constants.
  - A port-id typedef (PORT_A = 0, PORT_B = 1).
  - The tag struct {valid, port}.
- Sub-module ram_arb_pick holds the grant logic: a combinational winner plus the optional round-robin pointer register. It is the only part that changes under RAM_ARB_ROUND_ROBIN_EN.
- The top level holds the command registers, the tag pipeline and the response routing.

## Test plan
- Lone read: RAM[0x010]=0xBEEF, A_REQ read 0x010 in cycle t -> A_GNT in t, RAM_ENABLE=1 / ADDR=0x010 in t+1, A_RVALID=1 with A_RDATA=0xBEEF in t+2, B_RVALID=0 throughout.
- Write then read: B writes 0x1234 to 0xFFF, then reads 0xFFF in the next cycle -> B_RVALID two cycles in a row, RDATA 0x1234 then 0x1234.
- Conflict, round-robin build: A and B both read continuously for 6 cycles -> grants alternate A,B,A,B,A,B; responses alternate in the same order 2 cycles later.
- Conflict, fixed build: same stimulus -> A_GNT in all 6 cycles, B_GNT=0 until A_REQ drops, then B is granted in that cycle.
- Reset mid-flight: grant A read at t, pull RST_N low in t+1 -> no A_RVALID in t+2, all outputs 0 during reset, and the first conflict after release goes to A.
- Back-to-back mixed: A issues 8 alternating writes and reads over 0x000..0x003 -> one RAM_ENABLE per cycle, each read returns the value written just before it.
